// File: rtl/product_accumulator_if.sv
// rtl/product_accumulator_if.sv - product input and sum output handshakes of the accumulate stage
interface product_accumulator_if #(
  parameter int ACC_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_prod;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;
  logic             out_ovf;

  modport master (
    output in_valid, in_prod, out_ready,
    input  in_ready, out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_prod, out_ready,
    output in_ready, out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums a programmable number of 8-bit products into a wide accumulator
module product_accumulator #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 clear,
  input  logic [LEN_W-1:0]     len,
  output logic                 busy,
  product_accumulator_if.slave bus
);
  localparam int CNT_W = LEN_W + 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(1) << LEN_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]       state;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             out_valid_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] target;

  logic             in_hs;
  logic             out_hs;
  logic [ACC_W:0]   sum_ext;
  logic [CNT_W-1:0] cnt_inc;
  logic [CNT_W-1:0] first_target;

  assign bus.in_ready  = ena & ~clear & (state != S_HOLD);
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = acc;
  assign bus.out_ovf   = ovf;
  assign busy          = (state != S_IDLE);

  assign in_hs        = bus.in_valid & bus.in_ready;
  assign out_hs       = out_valid_q & bus.out_ready & ena;
  // The extra top bit of the sum is the carry that feeds the sticky overflow.
  assign sum_ext      = {1'b0, acc} + {{(ACC_W-7){1'b0}}, bus.in_prod};
  assign cnt_inc      = cnt + CNT_W'(1);
  assign first_target = (len == '0) ? MAX_CNT : {1'b0, len};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      acc         <= '0;
      ovf         <= 1'b0;
      out_valid_q <= 1'b0;
      cnt         <= '0;
      target      <= '0;
    end else if (ena) begin
      if (clear) begin
        state       <= S_IDLE;
        cnt         <= '0;
        out_valid_q <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (in_hs) begin
              target <= first_target;
              acc    <= ACC_W'(bus.in_prod);
              cnt    <= CNT_W'(1);
              ovf    <= 1'b0;
              if (first_target == CNT_W'(1)) begin
                state       <= S_HOLD;
                out_valid_q <= 1'b1;
              end else begin
                state <= S_ACC;
              end
            end
          end
          S_ACC: begin
            if (in_hs) begin
              acc <= sum_ext[ACC_W-1:0];
              ovf <= ovf | sum_ext[ACC_W];
              cnt <= cnt_inc;
              if (cnt_inc == target) begin
                state       <= S_HOLD;
                out_valid_q <= 1'b1;
              end
            end
          end
          S_HOLD: begin
            if (out_hs) begin
              state       <= S_IDLE;
              out_valid_q <= 1'b0;
            end
          end
          default: begin
            state       <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end
endmodule
